// File: rtl/key_event_pkg.sv
// Shared types and defaults for the key event decoder: FSM state encoding and ms timing constants.
package key_event_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StPress1 = 3'd1,
    StWait2  = 3'd2,
    StPress2 = 3'd3,
    StLong   = 3'd4
  } key_state_e;

  localparam int unsigned DefTickDiv = 100000;
  localparam int unsigned DefLongMs  = 1000;
  localparam int unsigned DefDblMs   = 300;
  localparam int unsigned DefRptMs   = 200;

  localparam int unsigned   MsW   = 16;
  localparam logic [MsW-1:0] MsMax = '1;

  // Timeouts fire on the tick that would take the ms count from N-1 to N.
  function automatic logic [MsW-1:0] ms_last(input int unsigned ms);
    return MsW'(ms - 1);
  endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Free-running prescaler producing a one-clk tick every TICK_DIV clk cycles.
module ms_tick_gen
  import key_event_pkg::*;
#(
  parameter int unsigned TICK_DIV = DefTickDiv
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned      CntW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TICK_DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CntLast);

  always_comb begin
    cnt_d = tick ? '0 : cnt_q + CntW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/key_event_decoder.sv
// Classifies a debounced key into short, double and long presses with optional auto-repeat.
// Auto-repeat on rpt_p is built only when KEY_AUTOREPEAT_EN is defined.
module key_event_decoder
  import key_event_pkg::*;
#(
  parameter int unsigned TICK_DIV = DefTickDiv,
  parameter int unsigned LONG_MS  = DefLongMs,
  parameter int unsigned DBL_MS   = DefDblMs,
  parameter int unsigned RPT_MS   = DefRptMs
) (
  input  logic clk,
  input  logic rst,
  input  logic key,
  output logic short_p,
  output logic dbl_p,
  output logic long_p,
  output logic rpt_p,
  output logic held
);

  localparam logic [MsW-1:0] LongLast = ms_last(LONG_MS);
  localparam logic [MsW-1:0] DblLast  = ms_last(DBL_MS);

  key_state_e     state_q, state_d;
  logic [MsW-1:0] ms_q, ms_d;
  logic           key_d_q;
  logic           tick, rise, fall, ms_clr;
  logic           short_q, short_d, dbl_q, dbl_d, long_q, long_d;

`ifdef KEY_AUTOREPEAT_EN
  localparam logic [MsW-1:0] RptLast = ms_last(RPT_MS);
  logic rpt_q, rpt_d;
`else
  logic unused_rpt_ms;
  assign unused_rpt_ms = ^RPT_MS;
`endif

  ms_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .tick(tick)
  );

  // key_d_q resets to 0, so a key already down at reset release reads as a rise.
  assign rise = key & ~key_d_q;
  assign fall = ~key & key_d_q;

  always_comb begin
    state_d = state_q;
    short_d = 1'b0;
    dbl_d   = 1'b0;
    long_d  = 1'b0;
    ms_clr  = 1'b0;
`ifdef KEY_AUTOREPEAT_EN
    rpt_d   = 1'b0;
`endif
    // Edges are tested before timeouts so a coincident edge always wins.
    case (state_q)
      StIdle: begin
        if (rise) state_d = StPress1;
      end
      StPress1: begin
        if (fall) begin
          state_d = StWait2;
        end else if (tick && ms_q == LongLast) begin
          state_d = StLong;
          long_d  = 1'b1;
        end
      end
      StWait2: begin
        if (rise) begin
          state_d = StPress2;
        end else if (tick && ms_q == DblLast) begin
          state_d = StIdle;
          short_d = 1'b1;
        end
      end
      StPress2: begin
        if (fall) begin
          state_d = StIdle;
          dbl_d   = 1'b1;
        end
      end
      StLong: begin
        if (fall) begin
          state_d = StIdle;
        end
`ifdef KEY_AUTOREPEAT_EN
        else if (tick && ms_q == RptLast) begin
          rpt_d  = 1'b1;
          ms_clr = 1'b1;
        end
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    ms_d = ms_q;
    if (state_d != state_q || ms_clr) begin
      ms_d = '0;
    end else if (tick && ms_q != MsMax) begin
      ms_d = ms_q + MsW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      ms_q    <= '0;
      key_d_q <= 1'b0;
      short_q <= 1'b0;
      dbl_q   <= 1'b0;
      long_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ms_q    <= ms_d;
      key_d_q <= key;
      short_q <= short_d;
      dbl_q   <= dbl_d;
      long_q  <= long_d;
    end
  end

`ifdef KEY_AUTOREPEAT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rpt_q <= 1'b0;
    end else begin
      rpt_q <= rpt_d;
    end
  end
  assign rpt_p = rpt_q;
`else
  assign rpt_p = 1'b0;
`endif

  assign short_p = short_q;
  assign dbl_p   = dbl_q;
  assign long_p  = long_q;
  assign held    = (state_q == StLong);

endmodule

// File: tb/tb_key_event_decoder.sv
// Directed bench for key_event_decoder at 10 clk/ms; repeat checks follow KEY_AUTOREPEAT_EN.
module tb_key_event_decoder;
  import key_event_pkg::*;

  localparam int unsigned TickDiv = 10;
  localparam int unsigned LongMs  = 20;
  localparam int unsigned DblMs   = 5;
  localparam int unsigned RptMs   = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic key = 1'b0;
  logic short_p, dbl_p, long_p, rpt_p, held;

  key_event_decoder #(
    .TICK_DIV(TickDiv),
    .LONG_MS (LongMs),
    .DBL_MS  (DblMs),
    .RPT_MS  (RptMs)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .key    (key),
    .short_p(short_p),
    .dbl_p  (dbl_p),
    .long_p (long_p),
    .rpt_p  (rpt_p),
    .held   (held)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor: counts, timestamps, overlap and width violations.
  int n_short = 0, n_dbl = 0, n_long = 0, n_multi = 0, n_wide = 0;
  int t_short = 0, t_dbl = 0, t_long = 0;
  int t_rpt[$];
  logic held_at_long = 1'b0;
  logic [3:0] prev_p = 4'd0;

  always @(negedge clk) begin
    logic [3:0] p;
    p = {short_p, dbl_p, long_p, rpt_p};
    if (p[3]) begin n_short++; t_short = cyc; end
    if (p[2]) begin n_dbl++;   t_dbl   = cyc; end
    if (p[1]) begin n_long++;  t_long  = cyc; held_at_long = held; end
    if (p[0]) t_rpt.push_back(cyc);
    if ($countones(p) > 1) n_multi++;
    if ((p & prev_p) != 4'd0) n_wide++;
    prev_p = p;
  end

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_win(input string tag, input int obs, input int lo, input int hi);
    n_cmp++;
    assert (obs >= lo && obs <= hi) else begin
      n_mis++;
      $error("FAIL %s: observed %0d, expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int b_s, b_d, b_l, b_r, t_rel, t_press, t_rst;
    logic found;

    // Reset state
    step(3);
    check("rst_short", {31'd0, short_p}, 0);
    check("rst_dbl", {31'd0, dbl_p}, 0);
    check("rst_long", {31'd0, long_p}, 0);
    check("rst_rpt", {31'd0, rpt_p}, 0);
    check("rst_held", {31'd0, held}, 0);
    check("rst_state", {29'd0, dut.state_q}, {29'd0, StIdle});
    rst = 1'b1;
    step(5);

    // Single short press: 5 ms down, short_p about 5 ms after release
    b_s = n_short; b_d = n_dbl; b_l = n_long;
    key = 1'b1;
    step(50);
    key = 1'b0;
    t_rel = cyc;
    step(80);
    check("short_count", n_short - b_s, 1);
    check_win("short_delay", t_short - t_rel, 40, 56);
    check("short_no_dbl", n_dbl - b_d, 0);
    check("short_no_long", n_long - b_l, 0);

    // Double press: 3 ms, gap 2 ms, 3 ms
    b_s = n_short; b_d = n_dbl; b_l = n_long;
    key = 1'b1; step(30);
    key = 1'b0; step(20);
    key = 1'b1; step(30);
    key = 1'b0;
    t_rel = cyc;
    step(100);
    check("dbl_count", n_dbl - b_d, 1);
    check("dbl_delay", t_dbl - t_rel, 1);
    check("dbl_no_short", n_short - b_s, 0);
    check("dbl_no_long", n_long - b_l, 0);

    // Long hold for 35 ms
    b_s = n_short; b_d = n_dbl; b_l = n_long; b_r = t_rpt.size();
    key = 1'b1;
    t_press = cyc;
    step(350);
    check("long_held_before_rel", {31'd0, held}, 1);
    key = 1'b0;
    t_rel = cyc;
    step(1);
    check("long_held_after_rel", {31'd0, held}, 0);
    step(20);
    check("long_count", n_long - b_l, 1);
    check_win("long_delay", t_long - t_press, 190, 205);
    check("long_held_with_pulse", {31'd0, held_at_long}, 1);
    check("long_no_short", n_short - b_s, 0);
    check("long_no_dbl", n_dbl - b_d, 0);
`ifdef KEY_AUTOREPEAT_EN
    check("rpt_count", t_rpt.size() - b_r, 3);
    if (t_rpt.size() - b_r >= 3) begin
      check("rpt_first", t_rpt[b_r] - t_long, 40);
      check("rpt_second", t_rpt[b_r + 1] - t_long, 80);
      check("rpt_third", t_rpt[b_r + 2] - t_long, 120);
    end
`else
    check("rpt_count", t_rpt.size() - b_r, 0);
`endif

    // Release coincident with the long timeout tick: fall wins
    b_s = n_short; b_l = n_long;
    key = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      step(1);
      if (dut.state_q == StPress1 && dut.tick && dut.ms_q == 16'(LongMs - 1)) found = 1'b1;
    end
    check("coinc_found", {31'd0, found}, 1);
    key = 1'b0;
    t_rel = cyc;
    step(1);
    check("coinc_state", {29'd0, dut.state_q}, {29'd0, StWait2});
    step(80);
    check("coinc_no_long", n_long - b_l, 0);
    check("coinc_short", n_short - b_s, 1);
    check_win("coinc_short_delay", t_short - t_rel, 40, 56);

    // Reset mid-press with key still down at release
    b_s = n_short; b_d = n_dbl; b_l = n_long; b_r = t_rpt.size();
    key = 1'b1;
    step(50);
    rst = 1'b0;
    step(1);
    check("mid_rst_state", {29'd0, dut.state_q}, {29'd0, StIdle});
    check("mid_rst_held", {31'd0, held}, 0);
    step(2);
    rst = 1'b1;
    t_rst = cyc;
    step(1);
    check("rerun_state", {29'd0, dut.state_q}, {29'd0, StPress1});
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      step(1);
      if (n_long != b_l) found = 1'b1;
    end
    check("rerun_long_seen", {31'd0, found}, 1);
    key = 1'b0;
    step(80);
    check_win("rerun_long_delay", t_long - t_rst, 190, 205);
    check("rerun_long_count", n_long - b_l, 1);
    check("rerun_no_short", n_short - b_s, 0);
    check("rerun_no_dbl", n_dbl - b_d, 0);
    check("rerun_no_rpt", t_rpt.size() - b_r, 0);

    // Whole-run pulse properties
    check("pulse_overlap", n_multi, 0);
    check("pulse_width", n_wide, 0);
`ifndef KEY_AUTOREPEAT_EN
    check("rpt_never", t_rpt.size(), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/key_event_decoder.md
KEY_EVENT_DECODER -- requirements
Module: key_event_decoder

Interface
REQ-001 SHALL have parameter TICK_DIV, default 100000, clk cycles per 1 ms tick (100 MHz board clock).
REQ-002 SHALL have parameter LONG_MS, default 1000, hold time in ms that qualifies a long press.
REQ-003 SHALL have parameter DBL_MS, default 300, max release-to-second-press gap in ms for a double press.
REQ-004 SHALL have parameter RPT_MS, default 200, auto-repeat period in ms.
REQ-005 SHALL have port clk, input, 1, system clock (rising edge).
REQ-006 SHALL have port rst, input, 1, reset, asynchronous, active-low.
REQ-007 SHALL have port key, input, 1, debounced key level in the clk domain, 1 = pressed.
REQ-008 SHALL have port short_p, output, 1, one-cycle pulse on a classified single short press.
REQ-009 SHALL have port dbl_p, output, 1, one-cycle pulse on a classified double press.
REQ-010 SHALL have port long_p, output, 1, one-cycle pulse when a hold reaches LONG_MS.
REQ-011 SHALL have port rpt_p, output, 1, one-cycle auto-repeat pulse during a long hold.
REQ-012 SHALL have port held, output, 1, level, high while the state is LONG.

Function
REQ-013 SHALL register key into key_d each clk; rise = key & ~key_d, fall = ~key & key_d.
REQ-014 SHALL generate a one-clk tick every TICK_DIV clk cycles from a free-running prescaler.
REQ-015 SHALL keep a 16-bit ms counter that is cleared on every state transition, increments on tick, and saturates at 65535.
REQ-016 SHALL implement the FSM states IDLE, PRESS1, WAIT2, PRESS2 and LONG.
REQ-017 In IDLE, on rise, SHALL move to PRESS1.
REQ-018 In PRESS1, on fall, SHALL move to WAIT2; else, on tick with ms count = LONG_MS-1, SHALL pulse long_p and move to LONG.
REQ-019 In WAIT2, on rise, SHALL move to PRESS2; else, on tick with ms count = DBL_MS-1, SHALL pulse short_p and move to IDLE.
REQ-020 In PRESS2, on fall, SHALL pulse dbl_p and move to IDLE, regardless of hold duration.
REQ-021 In LONG, on fall, SHALL move to IDLE without emitting a pulse.
REQ-022 When an edge and a timeout occur in the same cycle, the edge SHALL win (PRESS1: fall wins over long; WAIT2: rise wins over short).
REQ-023 All pulse outputs SHALL be registered, exactly one clk wide, and mutually exclusive in any cycle.
REQ-024 Timing accuracy SHALL be within one tick, because the prescaler phase is not aligned to key edges.

Reset
REQ-025 While rst = 0, all outputs, key_d, the prescaler, the ms counter and the FSM (IDLE) SHALL be 0 or IDLE.
REQ-026 If key = 1 at reset release, this SHALL be treated as a rise in the first cycle (press begins).
REQ-027 Reset asserted mid-press SHALL abort classification with no pulse emitted.

Configuration
REQ-028 The macro KEY_AUTOREPEAT_EN, when defined, SHALL make LONG pulse rpt_p on every tick where the ms count = RPT_MS-1 and then clear the ms counter; the first rpt_p SHALL occur RPT_MS after long_p.
REQ-029 When KEY_AUTOREPEAT_EN is undefined, rpt_p SHALL be tied to 0 and the repeat logic SHALL be absent.

Structure
REQ-030 Package key_event_pkg SHALL hold the FSM state encoding (3-bit) and the default ms constants.
REQ-031 The prescaler SHALL be a sub-module ms_tick_gen (parameter TICK_DIV; ports clk, rst, tick).

Verification (TICK_DIV=10, LONG_MS=20, DBL_MS=5, RPT_MS=4, KEY_AUTOREPEAT_EN defined)
REQ-032 Press for 5 ms, then release -> short_p single pulse 5 +/- 1 ms after release; no other pulses.
REQ-033 Press 3 ms, release 2 ms, press 3 ms, release -> dbl_p single pulse one clk after second fall; short_p never pulses.
REQ-034 Hold for 35 ms -> long_p at 20 +/- 1 ms; rpt_p at 24, 28, 32 ms; held high from long_p until one clk after release.
REQ-035 Fall coincident with the tick reaching LONG_MS-1 -> no long_p; FSM enters WAIT2; short_p follows later.
REQ-036 Reset pulsed mid-PRESS1, with key still high at release -> no pulse; new press timed from reset release; long_p 20 +/- 1 ms later.
REQ-037 Rebuild without KEY_AUTOREPEAT_EN, 35 ms hold -> long_p only; rpt_p constant 0.
